// File: rtl/nice_gemm_issuer.sv
// Initiator for the NICE GEMM protocol: holds a 13-word descriptor, issues six
// parameter beats plus one start beat, then waits for the multi-cycle response.
module nice_gemm_issuer #(
  parameter logic [6:0]  OPCODE         = 7'b0101011,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        nice_clk,
  input  logic        nice_rst_n,
  input  logic        desc_we,
  input  logic [3:0]  desc_idx,
  input  logic [31:0] desc_wdata,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err_code,
  output logic        nice_req_valid,
  input  logic        nice_req_ready,
  output logic [31:0] nice_req_instr,
  output logic [31:0] nice_req_rs1,
  output logic [31:0] nice_req_rs2,
  input  logic        nice_rsp_1cyc_err,
  input  logic        nice_rsp_multicyc_valid,
  output logic        nice_rsp_multicyc_ready,
  input  logic        nice_rsp_multicyc_err
);

  // state    | meaning
  // IDLE     | accept descriptor writes and go
  // CHECK    | confirm every descriptor word has been written
  // ISSUE    | present beat 0..6 until accepted
  // WAIT_RSP | wait for the multi-cycle response or timeout
  // FIN      | one-cycle done pulse, err_code valid
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT_RSP,
    S_FIN
  } state_t;

  localparam logic [2:0] ERR_OK         = 3'd0;
  localparam logic [2:0] ERR_INCOMPLETE = 3'd1;
  localparam logic [2:0] ERR_1CYC       = 3'd2;
  localparam logic [2:0] ERR_MULTICYC   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd4;
  localparam logic [2:0] LAST_BEAT      = 3'd6;

  state_t      state, state_n;
  logic [2:0]  beat, beat_n;
  logic [31:0] timer, timer_n, timer_inc;
  logic [2:0]  err_q, err_n;

  logic [31:0] desc [13];
  logic [12:0] desc_mask;

  logic        req_xfer;
  logic        rsp_xfer;
  logic [3:0]  rs1_idx;
  logic [3:0]  rs2_idx;
  logic [6:0]  funct7;

  // Descriptor is only writable while idle so a running sequence sees a frozen copy.
  always_ff @(posedge nice_clk) begin
    if (!nice_rst_n) begin
      desc_mask <= '0;
      for (int i = 0; i < 13; i++) begin
        desc[i] <= '0;
      end
    end else if (desc_we && (state == S_IDLE) && (desc_idx < 4'd13)) begin
      desc[desc_idx]      <= desc_wdata;
      desc_mask[desc_idx] <= 1'b1;
    end
  end

  always_ff @(posedge nice_clk) begin
    if (!nice_rst_n) begin
      state <= S_IDLE;
      beat  <= '0;
      timer <= '0;
      err_q <= ERR_OK;
    end else begin
      state <= state_n;
      beat  <= beat_n;
      timer <= timer_n;
      err_q <= err_n;
    end
  end

  assign req_xfer  = nice_req_valid && nice_req_ready;
  assign rsp_xfer  = nice_rsp_multicyc_valid && nice_rsp_multicyc_ready;
  assign timer_inc = (&timer) ? timer : timer + 32'd1;

  always_comb begin
    state_n = state;
    beat_n  = beat;
    timer_n = timer;
    err_n   = err_q;
    case (state)
      S_IDLE: begin
        if (go) begin
          err_n   = ERR_OK;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (&desc_mask) begin
          beat_n  = '0;
          state_n = S_ISSUE;
        end else begin
          err_n   = ERR_INCOMPLETE;
          state_n = S_FIN;
        end
      end
      S_ISSUE: begin
        if (req_xfer) begin
          if (beat == LAST_BEAT) begin
            timer_n = '0;
            state_n = S_WAIT_RSP;
          end else if (nice_rsp_1cyc_err) begin
            err_n   = ERR_1CYC;
            state_n = S_FIN;
          end else begin
            beat_n = beat + 3'd1;
          end
        end
      end
      S_WAIT_RSP: begin
        // A response landing on the timeout cycle takes priority.
        if (rsp_xfer) begin
          err_n   = nice_rsp_multicyc_err ? ERR_MULTICYC : ERR_OK;
          state_n = S_FIN;
        end else begin
          timer_n = timer_inc;
          if ((TIMEOUT_CYCLES != 0) && (timer_inc >= TIMEOUT_CYCLES)) begin
            err_n   = ERR_TIMEOUT;
            state_n = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Beat k carries words 2k/2k+1; the start beat carries word 12 alone.
  assign rs1_idx = {beat, 1'b0};
  assign rs2_idx = {beat, 1'b1};
  assign funct7  = (beat == LAST_BEAT) ? 7'b1000000 : (7'd1 << beat);

  always_comb begin
    nice_req_valid = 1'b0;
    nice_req_instr = '0;
    nice_req_rs1   = '0;
    nice_req_rs2   = '0;
    if (state == S_ISSUE) begin
      nice_req_valid = 1'b1;
      nice_req_instr = {funct7, 18'b0, OPCODE};
      nice_req_rs1   = desc[rs1_idx];
      nice_req_rs2   = (beat == LAST_BEAT) ? 32'd0 : desc[rs2_idx];
    end
  end

  assign nice_rsp_multicyc_ready = (state == S_WAIT_RSP);
  assign busy                    = (state != S_IDLE);
  assign done                    = (state == S_FIN);
  assign err_code                = err_q;

endmodule

// File: tb/tb_nice_gemm_issuer.sv
// Bench for nice_gemm_issuer: directed and randomized runs against a
// descriptor/sequence model, with an in-bench NICE responder.
module tb_nice_gemm_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        desc_we;
  logic [3:0]  desc_idx;
  logic [31:0] desc_wdata;
  logic        go;
  logic        busy;
  logic        done;
  logic [2:0]  err_code;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_instr;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        rsp_1cyc_err;
  logic        mc_valid;
  logic        mc_ready;
  logic        mc_err;

  always #5 clk = ~clk;

  nice_gemm_issuer #(.TIMEOUT_CYCLES(8)) dut (
    .nice_clk                (clk),
    .nice_rst_n              (rst_n),
    .desc_we                 (desc_we),
    .desc_idx                (desc_idx),
    .desc_wdata              (desc_wdata),
    .go                      (go),
    .busy                    (busy),
    .done                    (done),
    .err_code                (err_code),
    .nice_req_valid          (req_valid),
    .nice_req_ready          (req_ready),
    .nice_req_instr          (req_instr),
    .nice_req_rs1            (req_rs1),
    .nice_req_rs2            (req_rs2),
    .nice_rsp_1cyc_err       (rsp_1cyc_err),
    .nice_rsp_multicyc_valid (mc_valid),
    .nice_rsp_multicyc_ready (mc_ready),
    .nice_rsp_multicyc_err   (mc_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference descriptor
  logic [31:0] m_desc [13];
  logic [12:0] m_mask;

  // Monitor: records every accepted request and done pulse
  logic [31:0] xi [$];
  logic [31:0] x1 [$];
  logic [31:0] x2 [$];
  int          n_xfer = 0;
  int          n_done = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] p_instr, p_rs1, p_rs2;

  always @(posedge clk) begin
    if (rst_n && prev_stall &&
        (!req_valid || req_instr != p_instr || req_rs1 != p_rs1 || req_rs2 != p_rs2))
      stall_viol <= stall_viol + 1;
    prev_stall <= req_valid && !req_ready;
    p_instr    <= req_instr;
    p_rs1      <= req_rs1;
    p_rs2      <= req_rs2;
    if (req_valid && req_ready) begin
      xi.push_back(req_instr);
      x1.push_back(req_rs1);
      x2.push_back(req_rs2);
      n_xfer <= n_xfer + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  // Responder knobs for the current run
  int stall_cfg  = 0;
  int err_beat   = -1;
  int rsp_delay  = -1;
  int rsp_err    = 0;
  int base       = 0;
  int wait_cnt   = 0;
  int wrsp_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and drive the accelerator-side inputs for the new cycle.
  task automatic tick();
    @(negedge clk);
    if (req_valid) begin
      if (wait_cnt < stall_cfg) begin
        req_ready = 1'b0;
        wait_cnt++;
        rsp_1cyc_err = 1'($urandom);
      end else begin
        req_ready    = 1'b1;
        wait_cnt     = 0;
        rsp_1cyc_err = ((n_xfer - base) == err_beat);
      end
    end else begin
      req_ready    = 1'($urandom);
      rsp_1cyc_err = 1'($urandom);
      wait_cnt     = 0;
    end
    if (mc_ready) begin
      mc_valid = (wrsp_cnt == rsp_delay);
      mc_err   = (rsp_err != 0);
      wrsp_cnt++;
    end else begin
      mc_valid = 1'($urandom);
      mc_err   = 1'($urandom);
      wrsp_cnt = 0;
    end
  endtask

  task automatic write_word(input int idx, input logic [31:0] data);
    desc_we    = 1'b1;
    desc_idx   = 4'(idx);
    desc_wdata = data;
    tick();
    desc_we = 1'b0;
    if (idx < 13) begin
      m_desc[idx] = data;
      m_mask[idx] = 1'b1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".valid"},    32'(req_valid), 32'd0);
    check({tag, ".mc_ready"}, 32'(mc_ready),  32'd0);
    check({tag, ".busy"},     32'(busy),      32'd0);
    check({tag, ".done"},     32'(done),      32'd0);
    check({tag, ".err"},      32'(err_code),  32'd0);
    check({tag, ".instr"},    req_instr,      32'd0);
    check({tag, ".rs1"},      req_rs1,        32'd0);
    check({tag, ".rs2"},      req_rs2,        32'd0);
  endtask

  function automatic logic [31:0] exp_instr(input int k);
    logic [6:0] f;
    f = (k == 6) ? 7'b1000000 : (7'd1 << k);
    return {f, 18'b0, 7'b0101011};
  endfunction

  task automatic run(input string tag, input int s, input int eb, input int rd, input int re);
    int exp_err, exp_n, exp_lat, cyc, got_n, d0, lim;
    stall_cfg = s;
    err_beat  = eb;
    rsp_delay = rd;
    rsp_err   = re;
    base      = n_xfer;
    d0        = n_done;
    if (m_mask != 13'h1fff) begin
      exp_err = 1; exp_n = 0; exp_lat = 2;
    end else if (eb >= 0 && eb <= 5) begin
      exp_err = 2; exp_n = eb + 1; exp_lat = 2 + (eb + 1) * (s + 1);
    end else begin
      exp_n = 7;
      if (rd >= 0 && rd < 8) begin
        exp_err = (re != 0) ? 3 : 0;
        exp_lat = 2 + 7 * (s + 1) + rd + 1;
      end else begin
        exp_err = 4;
        exp_lat = 2 + 7 * (s + 1) + 8;
      end
    end
    go = 1'b1;
    tick();
    check({tag, ".busy_on_go"}, 32'(busy),     32'd1);
    check({tag, ".err_clear"},  32'(err_code), 32'd0);
    // Writes and go while busy must be ignored.
    desc_we    = 1'b1;
    desc_idx   = 4'($urandom);
    desc_wdata = $urandom;
    go         = 1'b1;
    cyc = 1;
    while (!done && cyc < 400) begin
      tick();
      desc_we = 1'b0;
      go      = 1'b0;
      cyc++;
    end
    desc_we = 1'b0;
    go      = 1'b0;
    check({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, ".err"},     32'(err_code), 32'(exp_err));
    got_n = n_xfer - base;
    check({tag, ".beats"},   32'(got_n), 32'(exp_n));
    lim = (got_n < exp_n) ? got_n : exp_n;
    for (int k = 0; k < lim; k++) begin
      check($sformatf("%s.instr%0d", tag, k), xi[base + k], exp_instr(k));
      check($sformatf("%s.rs1_%0d", tag, k), x1[base + k], (k == 6) ? m_desc[12] : m_desc[2 * k]);
      check($sformatf("%s.rs2_%0d", tag, k), x2[base + k], (k == 6) ? 32'd0 : m_desc[2 * k + 1]);
    end
    tick();
    check({tag, ".busy_drop"}, 32'(busy), 32'd0);
    check({tag, ".done_once"}, 32'(n_done - d0), 32'd1);
    check({tag, ".err_held"},  32'(err_code), 32'(exp_err));
  endtask

  initial begin
    int d0, cnt;
    rst_n = 1'b0; desc_we = 1'b0; desc_idx = '0; desc_wdata = '0; go = 1'b0;
    req_ready = 1'b0; rsp_1cyc_err = 1'b0; mc_valid = 1'b0; mc_err = 1'b0;
    m_mask = '0;
    for (int i = 0; i < 13; i++) m_desc[i] = '0;
    repeat (3) tick();
    check_quiet("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) write_word(i, 32'h10 + 32'(i));
    run("incomplete", 0, -1, 2, 0);

    write_word(12, 32'h1c);
    for (int i = 13; i < 16; i++) write_word(i, $urandom);
    run("basic", 0, -1, 2, 0);
    run("err1cyc_b2", 0, 2, -1, 0);
    run("stall5", 5, -1, 1, 0);
    run("timeout", 0, -1, -1, 0);
    run("mc_err", 0, -1, 0, 1);
    run("rsp_at_timeout", 0, -1, 7, 0);

    for (int r = 0; r < 8; r++) begin
      int eb;
      for (int i = 0; i < 13; i++) if ($urandom_range(0, 1) == 1) write_word(i, $urandom);
      eb = $urandom_range(0, 9);
      run($sformatf("rand%0d", r), $urandom_range(0, 3), (eb > 5) ? -1 : eb,
          $urandom_range(0, 10), $urandom_range(0, 1));
    end

    // Reset while beat 3 is on the bus
    stall_cfg = 0; err_beat = -1; rsp_delay = -1;
    base = n_xfer;
    go = 1'b1;
    tick();
    go = 1'b0;
    cnt = 0;
    while ((n_xfer - base) < 3 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("rst_mid.reached_b3", 32'(n_xfer - base), 32'd3);
    check("rst_mid.instr_b3", req_instr, exp_instr(3));
    d0 = n_done;
    rst_n = 1'b0;
    tick();
    check_quiet("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid.no_done", 32'(n_done - d0), 32'd0);
    m_mask = '0;
    for (int i = 0; i < 13; i++) m_desc[i] = '0;
    run("after_rst_empty", 0, -1, 0, 0);
    for (int i = 0; i < 13; i++) write_word(i, $urandom);
    run("after_rst_full", 0, -1, 3, 0);

    check("stall_stability", 32'(stall_viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
